// File: rtl/montgomery_modexp.sv
// Iterative base^exponent mod N built around a shared 4-stage Montgomery product unit.
// Define MONTGOMERY_MODEXP_SKIP_LZ_EN to start the bit scan at the highest set exponent bit.
module montgomery_modexp #(
   parameter int                WIDTH = 64,
   parameter int                EXP_W = 64,
   parameter logic [WIDTH-1:0]  N     = 64'hFFFFFFFFFFFFFFF1,
   parameter logic [WIDTH-1:0]  N_INV = 64'hEEEEEEEEEEEEEEEF,
   parameter logic [WIDTH-1:0]  R2    = 64'hE1,
   parameter logic [WIDTH-1:0]  R1    = 64'hF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] base,
   input  logic [EXP_W-1:0] exponent,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int IW  = (EXP_W > 1) ? $clog2(EXP_W) : 1;
   localparam int W2  = 2 * WIDTH;
   localparam int W2P = 2 * WIDTH + 1;
   localparam int WP1 = WIDTH + 1;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_CONV_IN  = 3'd1;
   localparam logic [2:0] S_SQR      = 3'd2;
   localparam logic [2:0] S_MUL      = 3'd3;
   localparam logic [2:0] S_CONV_OUT = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam logic [1:0] D_B = 2'd0;
   localparam logic [1:0] D_X = 2'd1;
   localparam logic [1:0] D_R = 2'd2;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [2:0]       state;
   logic [WIDTH-1:0] base_q;
   logic [EXP_W-1:0] exp_q;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] b_bar;
   logic [WIDTH-1:0] x_bar;

   logic             p1_v, p2_v, p3_v;
   logic [W2-1:0]    p1_t, p2_t;
   logic [WIDTH-1:0] p2_m;
   logic [WIDTH:0]   p3_t;
   logic [1:0]       p1_d, p2_d, p3_d;

   logic             pipe_busy;
   logic             issue;
   logic [WIDTH-1:0] op_a, op_b;
   logic [1:0]       op_d;
   logic [W2P-1:0]   sum3;
   logic [WIDTH-1:0] s_val;
   logic [IW-1:0]    start_idx;
   logic             skip_all;

`ifdef MONTGOMERY_MODEXP_SKIP_LZ_EN
   function automatic logic [IW-1:0] msb_index(input logic [EXP_W-1:0] e);
      msb_index = '0;
      for (int unsigned k = 0; k < EXP_W; k++) begin
         if (e[k]) msb_index = IW'(k);
      end
   endfunction

   always_comb begin
      start_idx = msb_index(exponent);
      skip_all  = (exp_q == '0);
   end
`else
   always_comb begin
      start_idx = IW'(EXP_W - 1);
      skip_all  = 1'b0;
   end
`endif

   // A new product may only start once stages 1-3 are empty; stage 4 writes straight into its destination.
   always_comb begin
      pipe_busy = p1_v | p2_v | p3_v;
      issue     = 1'b0;
      op_a      = x_bar;
      op_b      = x_bar;
      op_d      = D_X;
      case (state)
         S_CONV_IN: begin
            issue = !pipe_busy;
            op_a  = base_q;
            op_b  = R2;
            op_d  = D_B;
         end
         S_SQR: issue = !pipe_busy;
         S_MUL: begin
            issue = !pipe_busy;
            op_b  = b_bar;
         end
         S_CONV_OUT: begin
            issue = !pipe_busy;
            op_b  = ONE;
            op_d  = D_R;
         end
         default: issue = 1'b0;
      endcase
   end

   always_comb begin
      sum3  = W2P'(p2_t) + W2P'(p2_m) * W2P'(N);
      s_val = (p3_t >= {1'b0, N}) ? WIDTH'(p3_t - {1'b0, N}) : p3_t[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p1_v <= 1'b0;
         p2_v <= 1'b0;
         p3_v <= 1'b0;
      end else begin
         p1_v <= issue;
         p2_v <= p1_v;
         p3_v <= p2_v;
      end
      p1_t <= W2'(op_a) * W2'(op_b);
      p1_d <= op_d;
      p2_t <= p1_t;
      p2_m <= p1_t[WIDTH-1:0] * N_INV;
      p2_d <= p1_d;
      p3_t <= WP1'(sum3 >> WIDTH);
      p3_d <= p2_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         base_q    <= '0;
         exp_q     <= '0;
         idx       <= '0;
         b_bar     <= '0;
         x_bar     <= '0;
      end else begin
         if (p3_v) begin
            case (p3_d)
               D_B:     b_bar <= s_val;
               D_X:     x_bar <= s_val;
               default: begin
                  result    <= s_val;
                  out_valid <= 1'b1;
               end
            endcase
         end
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  base_q <= base;
                  exp_q  <= exponent;
                  idx    <= start_idx;
                  state  <= S_CONV_IN;
               end
            end
            S_CONV_IN: begin
               if (issue) begin
                  x_bar <= R1;
                  state <= skip_all ? S_CONV_OUT : S_SQR;
               end
            end
            // NEXT is folded into the SQR/MUL transitions.
            S_SQR: begin
               if (issue) begin
                  if (exp_q[idx]) begin
                     state <= S_MUL;
                  end else if (idx == '0) begin
                     state <= S_CONV_OUT;
                  end else begin
                     idx   <= idx - 1'b1;
                     state <= S_SQR;
                  end
               end
            end
            S_MUL: begin
               if (issue) begin
                  if (idx == '0) begin
                     state <= S_CONV_OUT;
                  end else begin
                     idx   <= idx - 1'b1;
                     state <= S_SQR;
                  end
               end
            end
            S_CONV_OUT: begin
               if (issue) state <= S_DONE;
            end
            S_DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready = (state == S_IDLE);
      busy     = (state != S_IDLE) && !out_valid;
   end

endmodule
